// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory bus bundle for load_store_unit
//
// Purpose : groups the execute-stage request, the pipeline response and the
//           data-memory req/ack bus into one interface.
// Modports: master - upstream pipeline plus memory model (drives requests, ack, rdata)
//           slave  - load_store_unit (drives stall, load result, dmem request)
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        timeout_err;

    modport master (
        output req_valid, mem_read, mem_write, funct3, alu_out, store_data,
               dmem_ack, dmem_rdata,
        input  req_ready, stall, load_data, load_valid, misaligned, timeout_err,
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, alu_out, store_data,
               dmem_ack, dmem_rdata,
        output req_ready, stall, load_data, load_valid, misaligned, timeout_err,
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V memory-stage load/store unit with req/ack data bus
//
// Purpose : one data-memory access at a time; byte enables, store lane
//           replication, load sign/zero extension, misalign rejection and
//           an ack timeout of MAX_WAIT cycles.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - load_store_unit_if.slave (request, response, dmem bus)
module load_store_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [2:0]    r_funct3;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [31:0]   r_load_data;
    logic          r_load_valid;
    logic          r_misaligned;
    logic          r_timeout;

    logic          w_accept;
    logic          w_bad;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_ext;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write);

    // Width codes 011/110/111 have no RISC-V load/store meaning and are rejected
    // through the same path as a misaligned address.
    always_comb begin
        w_bad = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: w_bad = 1'b0;
            3'b001, 3'b101: w_bad = bus.alu_out[0];
            3'b010:         w_bad = (bus.alu_out[1:0] != 2'b00);
            default:        w_bad = 1'b1;
        endcase
    end

    // Store lanes; a read carries no byte enables.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        if (bus.mem_write) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << bus.alu_out[1:0];
                    w_wdata = {4{bus.store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = bus.alu_out[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{bus.store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = bus.store_data;
                end
            endcase
        end
    end

    // Load lane select uses the latched byte offset of the in-flight access.
    always_comb begin
        w_byte = 8'h0;
        case (r_addr[1:0])
            2'b00: w_byte = bus.dmem_rdata[7:0];
            2'b01: w_byte = bus.dmem_rdata[15:8];
            2'b10: w_byte = bus.dmem_rdata[23:16];
            2'b11: w_byte = bus.dmem_rdata[31:24];
            default: w_byte = 8'h0;
        endcase
        w_half = r_addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'h0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= 32'h0;
            r_funct3     <= 3'b000;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_wdata      <= 32'h0;
            r_load_data  <= 32'h0;
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            // Response pulses live for exactly the RESP cycle.
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_bad) begin
                            r_misaligned <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_addr   <= bus.alu_out;
                            r_funct3 <= bus.funct3;
                            r_we     <= bus.mem_write;
                            r_be     <= w_be;
                            r_wdata  <= w_wdata;
                            r_cnt    <= CW'(1);
                            r_state  <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack on the final counted cycle still wins over the timeout.
                    if (bus.dmem_ack) begin
                        if (!r_we) begin
                            r_load_data  <= w_load_ext;
                            r_load_valid <= 1'b1;
                        end
                        r_cnt   <= '0;
                        r_state <= S_RESP;
                    end else if (r_cnt == CW'(MAX_WAIT)) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.stall       = w_accept || (r_state == S_WAIT);
    assign bus.dmem_req    = (r_state == S_WAIT);
    assign bus.dmem_we     = r_we;
    assign bus.dmem_addr   = {r_addr[31:2], 2'b00};
    assign bus.dmem_be     = r_be;
    assign bus.dmem_wdata  = r_wdata;
    assign bus.load_data   = r_load_data;
    assign bus.load_valid  = r_load_valid;
    assign bus.misaligned  = r_misaligned;
    assign bus.timeout_err = r_timeout;
endmodule
